multicycle_ctrl_fsm: RTL and testbench

Multi-cycle sequencer for the RV32I datapath. It replaces single-cycle decode with a FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK state machine, so one unified memory port with a ready handshake serves both instruction fetch and load/store. It drives IR/PC write enables, register-file write, memory request, ALU selects and the PC source mux. It halts on illegal opcodes or a memory stall timeout.

---
 rtl/multicycle_ctrl_fsm.sv | 244 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
//
// Multi-cycle sequencer for an RV32I datapath. One unified memory port with a
// ready handshake serves instruction fetch and load/store. The controller
// walks FETCH -> DECODE -> EXECUTE -> (MEMORY) -> (WRITEBACK) -> FETCH. It
// halts on an unknown opcode or when memory stalls for too long.
//
// Parameters
//   STALL_LIMIT   consecutive mem_ready=0 cycles tolerated in FETCH/MEMORY
//                 before a bus error; 0 disables the timeout
//
// Ports
//   clk            clock, rising edge
//   rst_n          synchronous reset, active-low (forces all outputs to 0)
//   instruction    IR contents, stable from DECODE until the next FETCH
//   branch_taken   ALU comparison result, used in EXECUTE
//   mem_ready      memory completes the current request this cycle
//   mem_req        memory request (fetch or data)
//   mem_we         1 = store, 0 = read
//   ir_write       latch fetched word into IR
//   pc_write       update PC
//   pc_src         00 pc+4, 01 branch, 10 jal, 11 jalr target
//   reg_write      register-file write enable
//   wb_sel         00 ALU, 01 memory data, 10 pc+4
//   alu_src        0 rs2, 1 immediate
//   alu_op         00 add, 01 compare/sub, 10 funct-decoded
//   illegal_instr  sticky: halted on unknown opcode
//   bus_error      sticky: halted on stall timeout
//   state          current state (0 FETCH .. 5 HALT)
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
   parameter int unsigned STALL_LIMIT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instruction,
   input  logic        branch_taken,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        ir_write,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic        reg_write,
   output logic [1:0]  wb_sel,
   output logic        alu_src,
   output logic [1:0]  alu_op,
   output logic        illegal_instr,
   output logic        bus_error,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_MEMORY    = 3'd3,
      S_WRITEBACK = 3'd4,
      S_HALT      = 3'd5
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IARITH = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // The counter only needs to hold LIMIT-1: the timeout fires on the
   // LIMIT-th consecutive wait cycle, when the count is already LIMIT-1.
   localparam int unsigned CNT_W      = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT);
   localparam int unsigned LIMIT_M1_I = (STALL_LIMIT == 0) ? 0 : STALL_LIMIT - 1;
   localparam logic [CNT_W-1:0] LIMIT_M1 = LIMIT_M1_I[CNT_W-1:0];

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             illegal_q, bus_err_q;
   logic             set_illegal, set_bus_err;

   logic [6:0] opcode;
   logic       is_r, is_ia, is_load, is_store, is_branch;
   logic       is_jal, is_jalr, is_lui, is_auipc, is_legal;
   logic       rd_nonzero;
   logic       stall_hit;

   // Opcode fields only; the remaining instruction bits belong to the datapath.
   logic unused_bits;
   assign unused_bits = ^instruction[31:12];

   assign opcode     = instruction[6:0];
   assign rd_nonzero = (instruction[11:7] != 5'd0);

   always_comb begin
      is_r      = (opcode == OP_R);
      is_ia     = (opcode == OP_IARITH);
      is_load   = (opcode == OP_LOAD);
      is_store  = (opcode == OP_STORE);
      is_branch = (opcode == OP_BRANCH);
      is_jal    = (opcode == OP_JAL);
      is_jalr   = (opcode == OP_JALR);
      is_lui    = (opcode == OP_LUI);
      is_auipc  = (opcode == OP_AUIPC);
      is_legal  = is_r | is_ia | is_load | is_store | is_branch |
                  is_jal | is_jalr | is_lui | is_auipc;
   end

   // A ready in the same cycle as the limit wins, hence the !mem_ready term.
   assign stall_hit = (STALL_LIMIT != 0) && !mem_ready && (cnt_q == LIMIT_M1);

   // State, stall counter and sticky flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         if (set_illegal) illegal_q <= 1'b1;
         if (set_bus_err) bus_err_q <= 1'b1;
      end
   end

   // Next state and strobes
   always_comb begin
      state_d       = state_q;
      cnt_d         = '0;
      set_illegal   = 1'b0;
      set_bus_err   = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_src        = 2'b00;
      reg_write     = 1'b0;
      wb_sel        = 2'b00;
      alu_src       = 1'b0;
      alu_op        = 2'b00;

      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               state_d  = S_DECODE;
            end else if (stall_hit) begin
               state_d     = S_HALT;
               set_bus_err = 1'b1;
            end
         end

         S_DECODE: begin
            if (is_legal) begin
               state_d = S_EXECUTE;
            end else begin
               state_d     = S_HALT;
               set_illegal = 1'b1;
            end
         end

         S_EXECUTE: begin
            if (is_r) begin
               alu_op = 2'b10;
            end else if (is_ia) begin
               alu_src = 1'b1;
               alu_op  = 2'b10;
            end else if (is_branch) begin
               alu_op   = 2'b01;
               pc_write = 1'b1;
               pc_src   = branch_taken ? 2'b01 : 2'b00;
            end else if (!is_jal) begin
               // load, store, LUI, AUIPC, JALR: address/immediate add
               alu_src = 1'b1;
            end

            if (is_branch)                state_d = S_FETCH;
            else if (is_load || is_store) state_d = S_MEMORY;
            else                          state_d = S_WRITEBACK;
         end

         S_MEMORY: begin
            mem_req = 1'b1;
            mem_we  = is_store;
            alu_src = 1'b1;
            if (mem_ready) begin
               if (is_store) begin
                  pc_write = 1'b1;
                  state_d  = S_FETCH;
               end else begin
                  state_d  = S_WRITEBACK;
               end
            end else if (stall_hit) begin
               state_d     = S_HALT;
               set_bus_err = 1'b1;
            end
         end

         S_WRITEBACK: begin
            reg_write = rd_nonzero;
            pc_write  = 1'b1;
            if (is_load)                wb_sel = 2'b01;
            else if (is_jal || is_jalr) wb_sel = 2'b10;
            if (is_jal)                 pc_src = 2'b10;
            else if (is_jalr)           pc_src = 2'b11;
            state_d = S_FETCH;
         end

         S_HALT: state_d = S_HALT;

         default: state_d = S_HALT;
      endcase

      // Count only uninterrupted waiting in the same memory state.
      if ((state_q == S_FETCH || state_q == S_MEMORY) && !mem_ready &&
          (state_d == state_q) && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + 1'b1;
      else if ((state_q == S_FETCH || state_q == S_MEMORY) && !mem_ready &&
               (state_d == state_q))
         cnt_d = cnt_q;

      // Reset holds every output low, including the memory request.
      if (!rst_n) begin
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         ir_write  = 1'b0;
         pc_write  = 1'b0;
         pc_src    = 2'b00;
         reg_write = 1'b0;
         wb_sel    = 2'b00;
         alu_src   = 1'b0;
         alu_op    = 2'b00;
      end
   end

   assign illegal_instr = rst_n & illegal_q;
   assign bus_error     = rst_n & bus_err_q;
   assign state         = rst_n ? state_q : S_FETCH;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;

   localparam int STALL = 4;

   typedef struct packed {
      logic [2:0] st;
      logic       mem_req;
      logic       mem_we;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       reg_write;
      logic [1:0] wb_sel;
      logic       alu_src;
      logic [1:0] alu_op;
      logic       illegal;
      logic       bus_err;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] instruction;
   logic        branch_taken;
   logic        mem_ready;
   logic        mem_req, mem_we, ir_write, pc_write, reg_write, alu_src;
   logic        illegal_instr, bus_error;
   logic [1:0]  pc_src, wb_sel, alu_op;
   logic [2:0]  state;

   exp_t  exp_q[$];
   string tag_q[$];
   int    checks;
   int    errors;
   bit    done;

   multicycle_ctrl_fsm #(.STALL_LIMIT(STALL)) dut (
      .clk(clk), .rst_n(rst_n), .instruction(instruction),
      .branch_taken(branch_taken), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
      .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
      .wb_sel(wb_sel), .alu_src(alu_src), .alu_op(alu_op),
      .illegal_instr(illegal_instr), .bus_error(bus_error), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction classes, straight from the opcode table.
   localparam int C_ILL = -1, C_R = 0, C_IA = 1, C_LD = 2, C_ST = 3, C_BR = 4,
                  C_JAL = 5, C_JALR = 6, C_LUI = 7, C_AUIPC = 8;

   logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                 7'b0010111};

   function automatic int iclass(input logic [6:0] op);
      for (int i = 0; i < 9; i++)
         if (legal_ops[i] == op) return i;
      return C_ILL;
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // Monitor: one expected output vector per clock, compared mid-cycle.
   always @(negedge clk) begin
      exp_t  e;
      exp_t  a;
      string t;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         a = '{st: state, mem_req: mem_req, mem_we: mem_we, ir_write: ir_write,
               pc_write: pc_write, pc_src: pc_src, reg_write: reg_write,
               wb_sel: wb_sel, alu_src: alu_src, alu_op: alu_op,
               illegal: illegal_instr, bus_err: bus_error};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL %s t=%0t got %b required %b", t, $time, a, e);
         end
         if (mem_we === 1'b1 && mem_req !== 1'b1) begin
            errors++;
            $display("FAIL %s t=%0t mem_we without mem_req", t, $time);
         end
      end else if (done) begin
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired with %0d expectations pending", exp_q.size());
      $fatal(1, "timeout");
   end

   // One clock of stimulus with its expected outputs.
   task automatic step(input logic rn, input logic rdy, input logic bt,
                       input exp_t e, input string tag);
      rst_n        = rn;
      mem_ready    = rdy;
      branch_taken = bt;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step(1'b0, rb(), rb(), exp_t'('0), "reset");
   endtask

   task automatic halt_cycles(input int n, input logic ill, input logic be);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e = '0; e.st = 3'd5; e.illegal = ill; e.bus_err = be;
         step(1'b1, rb(), rb(), e, "halt");
      end
   endtask

   // Whole-instruction reference: lists the cycles an instruction must take.
   // fw/mw are memory wait cycles; STALL or more means a timeout.
   // btm: -1 random branch_taken, else forced value.
   task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                            input int btm, input int hc, output bit halted);
      exp_t e;
      int   c;
      logic bt;
      halted      = 1'b0;
      instruction = ins;
      c           = iclass(ins[6:0]);

      for (int i = 0; i < fw && i < STALL; i++) begin
         e = '0; e.mem_req = 1'b1;
         step(1'b1, 1'b0, rb(), e, "fetch_wait");
      end
      if (fw >= STALL) begin
         halt_cycles(hc, 1'b0, 1'b1);
         halted = 1'b1;
         return;
      end
      e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1;
      step(1'b1, 1'b1, rb(), e, "fetch");

      e = '0; e.st = 3'd1;
      step(1'b1, rb(), rb(), e, "decode");
      if (c == C_ILL) begin
         halt_cycles(hc, 1'b1, 1'b0);
         halted = 1'b1;
         return;
      end

      bt = (btm < 0) ? rb() : 1'(btm);
      e = '0; e.st = 3'd2;
      case (c)
         C_R:  e.alu_op = 2'b10;
         C_IA: begin e.alu_src = 1'b1; e.alu_op = 2'b10; end
         C_BR: begin e.alu_op = 2'b01; e.pc_write = 1'b1; e.pc_src = bt ? 2'b01 : 2'b00; end
         C_JAL: ;
         default: e.alu_src = 1'b1;
      endcase
      step(1'b1, rb(), bt, e, "execute");
      if (c == C_BR) return;

      if (c == C_LD || c == C_ST) begin
         for (int i = 0; i < mw && i < STALL; i++) begin
            e = '0; e.st = 3'd3; e.mem_req = 1'b1; e.mem_we = (c == C_ST); e.alu_src = 1'b1;
            step(1'b1, 1'b0, rb(), e, "mem_wait");
         end
         if (mw >= STALL) begin
            halt_cycles(hc, 1'b0, 1'b1);
            halted = 1'b1;
            return;
         end
         e = '0; e.st = 3'd3; e.mem_req = 1'b1; e.mem_we = (c == C_ST); e.alu_src = 1'b1;
         e.pc_write = (c == C_ST);
         step(1'b1, 1'b1, rb(), e, "mem_done");
         if (c == C_ST) return;
      end

      e = '0; e.st = 3'd4; e.pc_write = 1'b1;
      e.reg_write = (ins[11:7] != 5'd0);
      e.wb_sel = (c == C_LD) ? 2'b01 : (c == C_JAL || c == C_JALR) ? 2'b10 : 2'b00;
      e.pc_src = (c == C_JAL) ? 2'b10 : (c == C_JALR) ? 2'b11 : 2'b00;
      step(1'b1, rb(), rb(), e, "writeback");
   endtask

   initial begin
      bit          h;
      exp_t        e;
      logic [31:0] r;
      logic [6:0]  op;
      int          fw, mw;

      checks = 0; errors = 0; done = 1'b0;
      rst_n = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0; instruction = '0;
      @(posedge clk); #1;
      do_reset();

      // Directed cases
      run_instr(32'h002081B3, 0, 0, -1, 0, h);           // add x3,x1,x2
      run_instr(32'h00812283, 0, 2, -1, 0, h);           // lw x5,8(x2), 2 waits
      run_instr(32'h00512623, 1, 1, -1, 0, h);           // sw x5,12(x2)
      run_instr(32'h00000063, 0, 0, 1, 0, h);            // beq taken
      run_instr(32'h00000063, 0, 0, 0, 0, h);            // beq not taken
      run_instr(32'h00100013, 0, 0, -1, 0, h);           // addi x0,x0,1
      run_instr(32'h00C000EF, 3, 0, -1, 0, h);           // jal, limit-1 waits
      run_instr(32'h000080E7, 0, 0, -1, 0, h);           // jalr
      run_instr(32'h00812283, 0, 3, -1, 0, h);           // lw, ready wins at limit
      run_instr(32'h00000000, 0, 0, -1, 20, h);          // illegal -> HALT
      do_reset();
      run_instr(32'h002081B3, STALL, 0, -1, 6, h);       // fetch timeout
      do_reset();
      run_instr(32'h00512623, 0, STALL, -1, 4, h);       // store timeout
      do_reset();

      // Reset in the middle of MEMORY
      instruction = 32'h00812283;
      e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1; step(1'b1, 1'b1, 1'b0, e, "mr_fetch");
      e = '0; e.st = 3'd1;                         step(1'b1, 1'b0, 1'b0, e, "mr_decode");
      e = '0; e.st = 3'd2; e.alu_src = 1'b1;       step(1'b1, 1'b0, 1'b0, e, "mr_execute");
      e = '0; e.st = 3'd3; e.mem_req = 1'b1; e.alu_src = 1'b1;
      step(1'b1, 1'b0, 1'b0, e, "mr_memory");
      do_reset();
      if (state !== 3'd0 || mem_req !== 1'b0 || illegal_instr !== 1'b0 ||
          bus_error !== 1'b0) begin
         errors++;
         $display("FAIL mid-memory reset t=%0t state=%0d mem_req=%b", $time, state, mem_req);
      end
      run_instr(32'h002081B3, 0, 0, -1, 0, h);

      // Randomized instruction stream
      for (int n = 0; n < 200; n++) begin
         r = $urandom();
         if ($urandom_range(0, 19) == 0) begin
            op = r[6:0];
            while (iclass(op) != C_ILL) op = op + 7'd1;
         end else begin
            op = legal_ops[$urandom_range(0, 8)];
         end
         fw = ($urandom_range(0, 24) == 0) ? STALL : $urandom_range(0, STALL - 1);
         mw = ($urandom_range(0, 24) == 0) ? STALL : $urandom_range(0, STALL - 1);
         if ($urandom_range(0, 1) == 0) fw = 0;
         run_instr({r[31:7], op}, fw, mw, -1, $urandom_range(1, 4), h);
         if (h) do_reset();
      end

      if (checks < 12) begin
         errors++;
         $display("FAIL only %0d checks performed", checks);
      end
      if (errors != 0)
         $display("FAIL %0d mismatches so far", errors);

      done = 1'b1;
   end

endmodule
